// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the pipelined floating-point adder/subtractor:
//   - 4-bit status codes, identical to the single-cycle FPU so existing
//     status decoders can be reused unchanged
//   - operand class decode helper (width-independent)
//   - one payload struct per pipeline stage
// Format: binary format {sign, exp[FPU_EXP_BITS], frac[FPU_MANT_BITS]}.
// The stage structs are sized from FPU_EXP_BITS / FPU_MANT_BITS. A package
// cannot take parameters, so these two localparams are the single place to
// re-size the datapath; the top-level parameters default to them and must
// be kept equal to them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package fpu_pkg;

   localparam int unsigned FPU_EXP_BITS  = 8;
   localparam int unsigned FPU_MANT_BITS = 23;
   localparam int unsigned FPU_W         = 1 + FPU_EXP_BITS + FPU_MANT_BITS;
   // implicit bit + fraction + guard/round/sticky
   localparam int unsigned FPU_SIG_BITS  = FPU_MANT_BITS + 4;
   // one extra bit for the carry-out of the magnitude add
   localparam int unsigned FPU_SUM_BITS  = FPU_MANT_BITS + 5;
   localparam int unsigned FPU_LZC_BITS  = $clog2(FPU_SIG_BITS + 1);

   localparam logic [3:0] S_EXACT   = 4'b0001;
   localparam logic [3:0] S_OVERFL  = 4'b0010;
   localparam logic [3:0] S_UNDERFL = 4'b0100;
   localparam logic [3:0] S_INEXACT = 4'b1000;
   localparam logic [3:0] S_INVALID = 4'b1001;

   typedef struct packed {
      logic is_nan;
      logic is_inf;
      logic is_zero;
      logic is_sub;
   } fp_class_t;

   // Works for any exponent/fraction width: the caller reduces its fields
   // to the three flags, so the helper itself carries no width.
   function automatic fp_class_t fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic frac_zero);
      fp_class_t c;
      c.is_nan  = exp_ones & ~frac_zero;
      c.is_inf  = exp_ones &  frac_zero;
      c.is_zero = exp_zero &  frac_zero;
      c.is_sub  = exp_zero & ~frac_zero;
      return c;
   endfunction

   // S1 -> S2: operands swapped (larger magnitude in sig_a) and aligned.
   typedef struct packed {
      logic                      valid;
      logic                      special;     // result fully decided in S1
      logic [FPU_W-1:0]          spec_data;
      logic [3:0]                spec_status;
      logic                      sign;        // effective sign of the larger operand
      logic                      sub;         // effective signs differ
      logic [FPU_EXP_BITS-1:0]   exp;         // effective exponent of the larger operand
      logic [FPU_SIG_BITS-1:0]   sig_a;
      logic [FPU_SIG_BITS-1:0]   sig_b;
   } s1_t;

   // S2 -> S3: raw magnitude sum and its leading-zero count.
   typedef struct packed {
      logic                      valid;
      logic                      special;
      logic [FPU_W-1:0]          spec_data;
      logic [3:0]                spec_status;
      logic                      sign;
      logic                      sub;
      logic [FPU_EXP_BITS-1:0]   exp;
      logic [FPU_SUM_BITS-1:0]   sum;
      logic [FPU_LZC_BITS-1:0]   lzc;
   } s2_t;

   // S3: the output register.
   typedef struct packed {
      logic                      valid;
      logic [FPU_W-1:0]          data;
      logic [3:0]                status;
   } s3_t;

endpackage

// File: rtl/fpu_lzc.sv
// ---------------------------------------------------------------------------
// fpu_lzc
// Combinational leading-zero counter.
//   data  : input vector, MSB first
//   count : number of zeros above the most significant one (WIDTH when zero)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fpu_lzc #(
   parameter int unsigned WIDTH = 27,
   localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   output logic [CW-1:0]    count
);

   // Scan upwards; the last one found is the most significant one.
   always_comb begin
      // NOTE: a default before any conditional assignment keeps this purely
      // combinational; a path that leaves count unassigned would infer a latch.
      count = CW'(WIDTH);
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (data[i]) count = CW'(int'(WIDTH) - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fpu_addsub_pipe
// Three-stage pipelined floating-point adder/subtractor with valid/ready
// handshake on both sides and a single global stall.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (accept = in_valid && in_ready)
//   op_a, op_b [W]        : operands {sign, exp, frac}
//   op_sel                : 0 = A+B, 1 = A-B
//   out_valid / out_ready : result handshake
//   data_out [W]          : result
//   status_out [4]        : EXACT/OVERFLOW/UNDERFLOW/INEXACT/INVALID
// Stages: S1 classify/swap/align, S2 add/sub + LZC, S3 normalise/round/pack.
// Build option: define FPU_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise results are truncated (round toward zero).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fpu_addsub_pipe
   import fpu_pkg::*;
#(
   parameter int unsigned  EXP_BITS  = FPU_EXP_BITS,
   parameter int unsigned  MANT_BITS = FPU_MANT_BITS,
   localparam int unsigned W         = 1 + EXP_BITS + MANT_BITS
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         op_sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] data_out,
   output logic [3:0]   status_out
);

   localparam int unsigned SIG = MANT_BITS + 4;
   localparam int unsigned SUM = MANT_BITS + 5;
   localparam int unsigned LZW = $clog2(SIG + 1);
   localparam int unsigned EXW = EXP_BITS + 1;
   localparam logic [EXP_BITS-1:0] EMAX = '1;

   s1_t  s1, s1_next;
   s2_t  s2, s2_next;
   s3_t  s3, s3_next;
   logic advance;

   // The whole pipe moves together; a held result freezes every stage.
   assign advance    = !s3.valid || out_ready;
   assign in_ready   = advance;
   assign out_valid  = s3.valid;
   assign data_out   = s3.data;
   assign status_out = s3.status;

   // ---------------- S1: classify, swap, align ----------------
   logic                sign_a, sign_b;
   logic [EXP_BITS-1:0] exp_a, exp_b;
   logic [MANT_BITS-1:0] frac_a, frac_b;
   fp_class_t           cls_a, cls_b;

   assign sign_a = op_a[W-1];
   assign exp_a  = op_a[W-2 -: EXP_BITS];
   assign frac_a = op_a[MANT_BITS-1:0];
   assign sign_b = op_b[W-1] ^ op_sel;        // subtraction = add with B negated
   assign exp_b  = op_b[W-2 -: EXP_BITS];
   assign frac_b = op_b[MANT_BITS-1:0];
   assign cls_a  = fp_classify(exp_a == '0, &exp_a, frac_a == '0);
   assign cls_b  = fp_classify(exp_b == '0, &exp_b, frac_b == '0);

   logic                swap, invalid;
   logic [EXP_BITS-1:0] eff_a, eff_b, exp_l, exp_s, diff;
   logic [SIG-1:0]      full_a, full_b, sig_l, sig_s, shifted, lost_mask;

   always_comb begin
      s1_next = '0;
      // Zero/subnormal exponents act as 1 with no implicit bit.
      eff_a  = (cls_a.is_zero || cls_a.is_sub) ? EXP_BITS'(1) : exp_a;
      eff_b  = (cls_b.is_zero || cls_b.is_sub) ? EXP_BITS'(1) : exp_b;
      full_a = {!(cls_a.is_zero || cls_a.is_sub), frac_a, 3'b000};
      full_b = {!(cls_b.is_zero || cls_b.is_sub), frac_b, 3'b000};

      // {exp, frac} orders magnitudes directly.
      swap  = {exp_b, frac_b} > {exp_a, frac_a};
      exp_l = swap ? eff_b  : eff_a;
      exp_s = swap ? eff_a  : eff_b;
      sig_l = swap ? full_b : full_a;
      sig_s = swap ? full_a : full_b;
      diff  = exp_l - exp_s;

      lost_mask = '0;
      if (32'(diff) >= 32'(MANT_BITS + 3)) begin
         shifted = SIG'(|sig_s);
      end else begin
         lost_mask  = ~({SIG{1'b1}} << diff);
         shifted    = sig_s >> diff;
         shifted[0] = shifted[0] | (|(sig_s & lost_mask));
      end

      invalid = cls_a.is_nan || cls_b.is_nan ||
                (cls_a.is_inf && cls_b.is_inf && (sign_a != sign_b));

      s1_next.valid   = in_valid;
      s1_next.special = invalid || cls_a.is_inf || cls_b.is_inf;
      if (invalid) begin
         s1_next.spec_data   = {1'b0, EMAX, 1'b1, {(MANT_BITS-1){1'b0}}};
         s1_next.spec_status = S_INVALID;
      end else if (cls_a.is_inf) begin
         s1_next.spec_data   = {sign_a, EMAX, {MANT_BITS{1'b0}}};
         s1_next.spec_status = S_EXACT;
      end else begin
         s1_next.spec_data   = {sign_b, EMAX, {MANT_BITS{1'b0}}};
         s1_next.spec_status = S_EXACT;
      end
      s1_next.sign  = swap ? sign_b : sign_a;
      s1_next.sub   = sign_a != sign_b;
      s1_next.exp   = exp_l;
      s1_next.sig_a = sig_l;
      s1_next.sig_b = shifted;
   end

   // ---------------- S2: add/sub, leading-zero count ----------------
   logic [SUM-1:0] sum;
   logic [LZW-1:0] lzc;

   // sig_a >= sig_b after the swap, so the difference never goes negative.
   assign sum = s1.sub ? ({1'b0, s1.sig_a} - {1'b0, s1.sig_b})
                       : ({1'b0, s1.sig_a} + {1'b0, s1.sig_b});

   fpu_lzc #(.WIDTH(SIG)) u_lzc (
      .data  (sum[SIG-1:0]),
      .count (lzc)
   );

   always_comb begin
      s2_next             = '0;
      s2_next.valid       = s1.valid;
      s2_next.special     = s1.special;
      s2_next.spec_data   = s1.spec_data;
      s2_next.spec_status = s1.spec_status;
      s2_next.sign        = s1.sign;
      s2_next.sub         = s1.sub;
      s2_next.exp         = s1.exp;
      s2_next.sum         = sum;
      s2_next.lzc         = lzc;
   end

   // ---------------- S3: normalise, round, pack, status ----------------
   logic [SIG-1:0]       norm;
   logic [EXW-1:0]       exp_n, exp_f;
   logic [31:0]          room, shamt;
   logic                 inexact, round_up, sign_f;
   logic [MANT_BITS+1:0] mant_r;
   logic [MANT_BITS-1:0] frac_f;

   always_comb begin
      s3_next = '0;
      room    = '0;
      shamt   = '0;
      if (s2.sum[SUM-1]) begin
         // Carry-out: one right shift, the dropped bit folds into sticky.
         norm    = s2.sum[SUM-1:1];
         norm[0] = s2.sum[1] | s2.sum[0];
         exp_n   = {1'b0, s2.exp} + EXW'(1);
      end else begin
         // Left shift limited so the exponent stays at 1 or above.
         room  = 32'(s2.exp) - 32'd1;
         shamt = (32'(s2.lzc) < room) ? 32'(s2.lzc) : room;
         norm  = s2.sum[SIG-1:0] << shamt;
         exp_n = {1'b0, s2.exp} - EXW'(shamt);
      end
      if (!norm[SIG-1]) exp_n = '0;          // no implicit bit: subnormal/zero

      inexact = |norm[2:0];
`ifdef FPU_ROUND_NEAREST_EN
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
      round_up = 1'b0;
`endif
      mant_r = {1'b0, norm[SIG-1:3]} + (MANT_BITS+2)'(round_up);

      if (mant_r[MANT_BITS+1]) begin         // rounding carried past the implicit bit
         exp_f  = exp_n + EXW'(1);
         frac_f = mant_r[MANT_BITS:1];
      end else if (exp_n == '0 && mant_r[MANT_BITS]) begin   // subnormal rounded up to normal
         exp_f  = EXW'(1);
         frac_f = mant_r[MANT_BITS-1:0];
      end else begin
         exp_f  = exp_n;
         frac_f = mant_r[MANT_BITS-1:0];
      end

      // Exact cancellation gives +0; two zeros of the same sign keep it.
      sign_f = (s2.sum == '0 && s2.sub) ? 1'b0 : s2.sign;

      s3_next.valid = s2.valid;
      if (s2.special) begin
         s3_next.data   = s2.spec_data;
         s3_next.status = s2.spec_status;
      end else if (exp_f >= {1'b0, EMAX}) begin
         s3_next.data   = {sign_f, EMAX, {MANT_BITS{1'b0}}};
         s3_next.status = S_OVERFL;
      end else begin
         s3_next.data = {sign_f, exp_f[EXP_BITS-1:0], frac_f};
         if (exp_f == '0 && frac_f != '0) s3_next.status = S_UNDERFL;
         else if (inexact)                s3_next.status = S_INEXACT;
         else                             s3_next.status = S_EXACT;
      end
   end

   // ---------------- stage registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else if (advance) begin
         // NOTE: non-blocking so every stage samples its predecessor's
         // pre-edge value; blocking here would ripple one op through all stages.
         s1 <= s1_next;
         s2 <= s2_next;
         s3 <= s3_next;
      end
   end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpu_addsub_pipe
// Directed self-checking bench for fpu_addsub_pipe (binary32 defaults).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpu_addsub_pipe;

   localparam logic [3:0] ST_EXACT = 4'b0001;
   localparam logic [3:0] ST_OVF   = 4'b0010;
   localparam logic [3:0] ST_UNF   = 4'b0100;
   localparam logic [3:0] ST_INEX  = 4'b1000;
   localparam logic [3:0] ST_INV   = 4'b1001;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        op_sel = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] data_out;
   logic [3:0]  status_out;

   int checks = 0;
   int errors = 0;

   fpu_addsub_pipe dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_sel     (op_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .status_out (status_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One isolated operation on an empty pipe; checks accept, latency and result.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sel, input logic [31:0] exp_d, input logic [3:0] exp_s);
      int lat;
      @(negedge clk);
      op_a = a; op_b = b; op_sel = sel; in_valid = 1'b1;
      #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".latency"}, 32'(lat), 32'd3);
      check({tag, ".data"}, data_out, exp_d);
      check({tag, ".status"}, 32'(status_out), 32'(exp_s));
   endtask

   logic [31:0] st_a [8];
   logic [31:0] st_b [8];
   logic        st_s [8];
   logic [31:0] st_r [8];

   initial begin
      int in_idx, out_idx;

      // ---- reset state ----
      #3;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.data", data_out, 32'd0);
      check("rst.status", 32'(status_out), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1 check("rel.in_ready", 32'(in_ready), 32'd1);

      // ---- basic, cancellation, specials ----
      run_op("add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, ST_EXACT);
      run_op("sub_1_1",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, ST_EXACT);
      run_op("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, ST_INV);
      run_op("nan_a",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, ST_INV);
      run_op("one_m_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, ST_EXACT);
      run_op("ninf_p_1",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, ST_EXACT);
      // ---- overflow / underflow ----
      run_op("max_p_max",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, ST_OVF);
      run_op("sub_p_sub",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, ST_UNF);
      run_op("norm_to_sub",32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, ST_UNF);
      run_op("lsb_cancel", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, ST_EXACT);
      // ---- rounding ----
`ifdef FPU_ROUND_NEAREST_EN
      run_op("round_gr",   32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, ST_INEX);
      run_op("round_ovf",  32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, ST_OVF);
`else
      run_op("round_gr",   32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, ST_INEX);
      run_op("round_ovf",  32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F7FFFFF, ST_INEX);
`endif
      run_op("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, ST_INEX);
      run_op("far_sticky", 32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, ST_INEX);

      // ---- streaming with a 4-cycle output stall ----
      st_a = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000,
               32'h3F800001, 32'h00400000, 32'h80000000, 32'h7F800000};
      st_b = '{32'h40000000, 32'h3F800000, 32'hBF800000, 32'h40000000,
               32'h3F800000, 32'h00400000, 32'h80000000, 32'h3F800000};
      st_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      st_r = '{32'h40400000, 32'h40000000, 32'h3F800000, 32'hBF800000,
               32'h34000000, 32'h00800000, 32'h80000000, 32'h7F800000};
      in_idx  = 0;
      out_idx = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         out_ready = !(c >= 6 && c < 10);
         if (in_idx < 8) begin
            in_valid = 1'b1;
            op_a = st_a[in_idx]; op_b = st_b[in_idx]; op_sel = st_s[in_idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) begin
            check("stall.in_ready", 32'(in_ready), 32'd0);
            check("stall.out_valid", 32'(out_valid), 32'd1);
         end
         if (out_valid && out_ready) begin
            if (out_idx < 8) begin
               check($sformatf("stream%0d.data", out_idx), data_out, st_r[out_idx]);
               check($sformatf("stream%0d.status", out_idx), 32'(status_out), 32'(ST_EXACT));
            end
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream.accepted", 32'(in_idx), 32'd8);
      check("stream.emitted", 32'(out_idx), 32'd8);

      // ---- asynchronous reset with three ops in flight ----
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op_a = st_a[i]; op_b = st_b[i]; op_sel = st_s[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("inflight.out_valid", 32'(out_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.data", data_out, 32'd0);
      check("midrst.status", 32'(status_out), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 check("postrst.no_survivor", 32'(out_valid), 32'd0);
      end
      run_op("after_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, ST_EXACT);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_addsub_pipe.md
# fpu_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshaking on both sides. It is the next-generation FPU datapath: configurable exponent and mantissa widths, one operation accepted per cycle, three-cycle latency and full backpressure. Special-case handling and the 4-bit status encoding are unchanged from the current single-cycle FPU, so downstream status decoders are reused as-is.

## Interface
- EXP_BITS, 8, exponent field width (≥3)
- MANT_BITS, 23, stored fraction width (≥4)
- W (localparam), 1+EXP_BITS+MANT_BITS, operand/result width
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands and op present
- in_ready  out  1  block accepts operands this cycle
- op_a, op_b  in  W  operands {sign, exp, frac}
- op_sel  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- data_out  out  W  result
- status_out  out  4  EXACT 0001, OVERFLOW 0010, UNDERFLOW 0100, INEXACT 1000, INVALID 1001

## Operation
- Subtraction is addition with sign_b inverted. Exponent 0 means implicit bit 0, with effective exponent 1 (subnormal). All-ones exponent means Inf when frac = 0, NaN otherwise.
- Specials, in priority order:
  - Any NaN, or Inf + (−Inf) after the effective sign flip: result is qNaN {0, all-ones exp, frac MSB 1, rest 0}, status INVALID.
  - Otherwise, if either operand is Inf: that Inf (sign after flip for B), status EXACT.
- Finite path:
  - Swap so the larger magnitude is A; result sign is A's effective sign.
  - Align B right by the exponent difference, keeping guard, round and sticky bits. A shift ≥ MANT_BITS+3 leaves only sticky.
  - Add or subtract magnitudes (MANT_BITS+5 bits including carry).
  - Normalise. On carry-out: right shift by 1, exp+1, shifted-out bit ORed into sticky. Otherwise: left shift by the leading-zero count, clamped so exp does not go below 1; a result still lacking the implicit bit is encoded with exp 0.
  - Round (see Configuration). A rounding carry renormalises; subnormal→normal and max→overflow are both legal.
- Zero result from x + (−x): +0. (−0) + (−0) gives −0.
- Status precedence: OVERFLOW (exp reaches all-ones; result ±Inf, frac 0) > UNDERFLOW (final exp 0 and frac ≠ 0) > INEXACT (any G/R/S bit set before rounding) > EXACT.

## Timing
- Three register stages:
  - S1: classify, swap, align.
  - S2: add/sub and leading-zero count.
  - S3: normalise, round, pack, status.
- Latency is 3 cycles from accept to out_valid when out_ready is held high; throughput is 1 per cycle.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready; in_ready = advance. While stalled, all stage registers, data_out and status_out hold.
- Bubbles: invalid stage slots still shift on advance, so bubbles collapse only at the output.
- Reset, async and possibly mid-operation: all stage valids clear, out_valid = 0, data_out = 0, status_out = 0000. in_ready = 1 once reset is released. No in-flight result survives reset.

## Configuration
- FPU_ROUND_NEAREST_EN defined: round to nearest, ties to even, using G/R/S.
- FPU_ROUND_NEAREST_EN undefined: truncate (round toward zero). OVERFLOW still yields ±Inf. The INEXACT flag is computed identically in both modes.

## Structure
- Package fpu_pkg holds:
  - The status localparams S_EXACT, S_OVERFL, S_UNDERFL, S_INEXACT, S_INVALID.
  - A parametrised class-decode helper function (is_nan, is_inf, is_zero, is_sub).
  - A stage-payload struct typedef per stage, sized from EXP_BITS and MANT_BITS.
- Sub-module fpu_lzc (parameter WIDTH): combinational leading-zero counter, instantiated in S2.

## Test plan
All scenarios use defaults (binary32) with out_ready = 1 unless stated.
1. 3F800000 + 40000000 → 40400000, status 0001, out_valid exactly 3 cycles after accept.
2. 3F800000 − 3F800000 → 00000000, status 0001. 7F800000 − 7F800000 → 7FC00000, status 1001. 7FC00001 + 3F800000 → 7FC00000, status 1001.
3. 7F7FFFFF + 7F7FFFFF → 7F800000, status 0010. 00000001 + 00000001 → 00000002, status 0100.
4. 3F800000 + 33C00000 → 3F800001 with the macro, 3F800000 without; status 1000 in both builds.
5. Back-to-back stream of 8 ops with out_ready low for 4 cycles mid-stream → in_ready low during the stall, no result lost or duplicated, results in order.
6. reset_n pulsed low with 3 ops in flight → out_valid 0, data_out 0, status 0000 immediately; the next op after release completes normally.
